alu_cmd_parser: RTL

- Framing stage directly downstream of the UART receiver and upstream of the ALU core.
- Consumes the RX byte stream and assembles 9-byte command frames: opcode, operand A (4 bytes, LSB first), operand B (4 bytes, LSB first).
- Presents one complete command to the ALU over a valid/ready handshake.
- Rejects unknown opcodes by pulsing an error strobe.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_cmd_parser_le_word_assembler.sv | 20 ++
 rtl/alu_cmd_parser.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU command definitions: opcode encoding, frame geometry and opcode check.
package alu_pkg;

  typedef enum logic [7:0] {
    OP_ECHO = 8'hEC,
    OP_ADD  = 8'hA0,
    OP_MUL  = 8'hA1,
    OP_DIV  = 8'hA2
  } alu_op_e;

  localparam int FRAME_BYTES   = 9;
  localparam int OPERAND_BYTES = 4;

  function automatic logic is_valid_op(input logic [7:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_ECHO, OP_ADD, OP_MUL, OP_DIV: ok = 1'b1;
      default:                          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_cmd_parser_le_word_assembler.sv
// Little-endian 32-bit word builder: byte idx lands in word[8*idx+7:8*idx]; clr zeroes the word.
module le_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [1:0]  idx,
  input  logic [7:0]  data,
  output logic [31:0] word
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word <= '0;
    end else if (load) begin
      word[{idx, 3'b000} +: 8] <= data;
    end
  end

endmodule

// File: rtl/alu_cmd_parser.sv
// Assembles 9-byte ALU command frames (opcode, A LSB-first, B LSB-first) from the UART byte stream.
// Build option: define PKT_TIMEOUT_EN to abort a frame after TIMEOUT_CYCLES idle clocks mid-frame.
module alu_cmd_parser
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  cmd_opcode_o,
  output logic [31:0] cmd_a_o,
  output logic [31:0] cmd_b_o,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic        err_o,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid may not drop before that edge and ready never depends on the partner's valid.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPA  = 2'd1,
    S_OPB  = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e      state, state_n;
  logic [1:0]  byte_cnt, byte_cnt_n;
  logic [7:0]  opcode_q;
  logic        err_q, err_n;
  logic        op_load, words_clr, a_load, b_load;
  logic        accept;

  assign rx_ready_o   = (state != S_HOLD);
  assign cmd_valid_o  = (state == S_HOLD);
  assign cmd_opcode_o = opcode_q;
  assign err_o        = err_q;
  assign dbg_state_o  = state;
  assign accept       = rx_valid_i && rx_ready_o;

`ifdef PKT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_n;

  always_ff @(posedge clk_i) begin
    if (rst_i) tmo_q <= '0;
    else       tmo_q <= tmo_n;
  end
`else
  localparam int tmo_unused = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      byte_cnt <= 2'd0;
      opcode_q <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      byte_cnt <= byte_cnt_n;
      err_q    <= err_n;
      if (op_load) opcode_q <= rx_data_i;
    end
  end

  always_comb begin
    state_n    = state;
    byte_cnt_n = byte_cnt;
    err_n      = 1'b0;
    op_load    = 1'b0;
    words_clr  = 1'b0;
    a_load     = 1'b0;
    b_load     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_valid_op(rx_data_i)) begin
            op_load    = 1'b1;
            words_clr  = 1'b1;
            byte_cnt_n = 2'd0;
            state_n    = S_OPA;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_OPA: begin
        if (accept) begin
          a_load     = 1'b1;
          byte_cnt_n = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) state_n = S_OPB;
        end
      end
      S_OPB: begin
        if (accept) begin
          b_load     = 1'b1;
          byte_cnt_n = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cmd_ready_i) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

`ifdef PKT_TIMEOUT_EN
    // The counter only runs while a frame is partially received; an accept always wins.
    tmo_n = '0;
    if ((state == S_OPA || state == S_OPB) && !accept) begin
      if (tmo_q == TMO_LAST) begin
        state_n    = S_IDLE;
        byte_cnt_n = 2'd0;
        err_n      = 1'b1;
      end else begin
        tmo_n = tmo_q + 1'b1;
      end
    end
`endif
  end

  le_word_assembler u_word_a (
    .clk  (clk_i),
    .rst  (rst_i),
    .clr  (words_clr),
    .load (a_load),
    .idx  (byte_cnt),
    .data (rx_data_i),
    .word (cmd_a_o)
  );

  le_word_assembler u_word_b (
    .clk  (clk_i),
    .rst  (rst_i),
    .clr  (words_clr),
    .load (b_load),
    .idx  (byte_cnt),
    .data (rx_data_i),
    .word (cmd_b_o)
  );

endmodule
